// File: rtl/vga_pkg.sv
// Display geometry shared by the video pipeline and the game logic.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
endpackage

// File: rtl/score_controller.sv
// Pong match controller: start-button synchroniser, miss detection, scoring,
// and the IDLE/SERVE/PLAY/OVER match FSM driving ball_hold.
module score_controller
    import vga_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120,
    parameter int MISS_MARGIN = 8,
    parameter int BALL_SIZE   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic [10:0] x_ball,
    input  logic        start_btn,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  game_state,
    output logic        ball_hold,
    output logic [1:0]  winner,
    output logic        point_pulse
);

    localparam logic [10:0] LEFT_EDGE  = 11'(MISS_MARGIN);
    localparam logic [10:0] RIGHT_EDGE = 11'(HOR_PIXELS - BALL_SIZE - MISS_MARGIN);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    state_t      state, next_state;
    logic        sync_1, sync_2, sync_3;
    logic        primed, armed, start;
    logic [7:0]  serve_cnt, cnt_nxt;
    logic [3:0]  sl_nxt, sr_nxt;
    logic [1:0]  win_nxt;
    logic        pulse_nxt;
    logic        miss_left, miss_right, point, win_point;
    logic [3:0]  left_inc, right_inc;

    // A button held through reset must be seen low before edges are honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
            start  <= 1'b0;
        end else begin
            sync_1 <= start_btn;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            primed <= 1'b1;
            if (primed && !sync_1 && !sync_2)
                armed <= 1'b1;
            start <= sync_2 & ~sync_3 & armed;
        end
    end

    assign miss_left  = (x_ball <= LEFT_EDGE);
    assign miss_right = (x_ball >= RIGHT_EDGE);
    assign point      = (state == PLAY) && timing_tick && (miss_left || miss_right);
    assign left_inc   = score_left + 4'd1;
    assign right_inc  = score_right + 4'd1;
    assign win_point  = miss_left ? (right_inc == WIN) : (left_inc == WIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            winner      <= 2'b00;
            point_pulse <= 1'b0;
            ball_hold   <= 1'b1;
            serve_cnt   <= 8'd0;
        end else begin
            state       <= next_state;
            score_left  <= sl_nxt;
            score_right <= sr_nxt;
            winner      <= win_nxt;
            point_pulse <= pulse_nxt;
            ball_hold   <= (next_state != PLAY);
            serve_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SERVE;
            SERVE:   if (timing_tick && serve_cnt == SERVE_LAST) next_state = PLAY;
            PLAY:    if (point) next_state = win_point ? OVER : SERVE;
            OVER:    if (start) next_state = SERVE;
            default: next_state = IDLE;
        endcase
    end

    // Misses at both edges at once credit the right player only.
    always_comb begin
        sl_nxt    = score_left;
        sr_nxt    = score_right;
        win_nxt   = winner;
        pulse_nxt = 1'b0;
        cnt_nxt   = serve_cnt;
        if ((state == IDLE || state == OVER) && start) begin
            sl_nxt  = 4'd0;
            sr_nxt  = 4'd0;
            win_nxt = 2'b00;
        end
        if (point) begin
            pulse_nxt = 1'b1;
            if (miss_left) begin
                sr_nxt = right_inc;
                if (win_point) win_nxt = 2'b10;
            end else begin
                sl_nxt = left_inc;
                if (win_point) win_nxt = 2'b01;
            end
        end
        if (next_state == SERVE && state != SERVE)
            cnt_nxt = 8'd0;
        else if (state == SERVE && timing_tick)
            cnt_nxt = serve_cnt + 8'd1;
    end

    assign game_state = state;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with SERVE_TICKS=4: vector table plus
// hand-written win, button-ignore and mid-match reset sequences.
module tb_score_controller;

    logic        clk = 1'b0;
    logic        rst, timing_tick, start_btn;
    logic [10:0] x_ball;
    logic [3:0]  score_left, score_right;
    logic [1:0]  game_state, winner;
    logic        ball_hold, point_pulse;

    int total = 0;
    int bad   = 0;

    score_controller #(.WIN_SCORE(7), .SERVE_TICKS(4), .MISS_MARGIN(8), .BALL_SIZE(15)) dut (
        .clk(clk), .rst(rst), .timing_tick(timing_tick), .x_ball(x_ball),
        .start_btn(start_btn), .score_left(score_left), .score_right(score_right),
        .game_state(game_state), .ball_hold(ball_hold), .winner(winner),
        .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, tick, btn;
        logic [10:0] x;
        logic [1:0]  st;
        logic [3:0]  sl, sr;
        logic [1:0]  w;
        logic        hold, pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic t, input logic b, input logic [10:0] x,
                       input logic [1:0] st, input logic [3:0] sl, input logic [3:0] sr,
                       input logic [1:0] w, input logic h, input logic p);
        vec_t v;
        v.rst = r; v.tick = t; v.btn = b; v.x = x;
        v.st = st; v.sl = sl; v.sr = sr; v.w = w; v.hold = h; v.pulse = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input int st, input int sl, input int sr,
                           input int w, input int h, input int p);
        chk({name, ".state"}, game_state, st);
        chk({name, ".sl"}, score_left, sl);
        chk({name, ".sr"}, score_right, sr);
        chk({name, ".winner"}, winner, w);
        chk({name, ".hold"}, ball_hold, h);
        chk({name, ".pulse"}, point_pulse, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_serve();
        timing_tick = 1'b1;
        x_ball = 11'd500;
        repeat (4) step();
        timing_tick = 1'b0;
    endtask

    task automatic do_point(input logic [10:0] x);
        timing_tick = 1'b1;
        x_ball = x;
        step();
        timing_tick = 1'b0;
        x_ball = 11'd500;
    endtask

    task automatic press();
        start_btn = 1'b1;
        repeat (4) step();
        start_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; timing_tick = 1'b0; start_btn = 1'b0; x_ball = 11'd500;
        //   rst tk btn x      st sl sr w  h  p
        add(1, 0, 0, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 500,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 500,  1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 500,  1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 500,  1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 500,  1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 500,  2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 8,    2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8,    1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 8,    1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 8,    1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 500,  1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 500,  1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 500,  1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 500,  1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 500,  1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 500,  2, 0, 1, 0, 0, 0);
        add(0, 1, 0, 9,    2, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1000, 2, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1001, 1, 1, 1, 0, 1, 1);
        add(0, 0, 0, 500,  1, 1, 1, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; timing_tick = vecs[i].tick;
            start_btn = vecs[i].btn; x_ball = vecs[i].x;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sl, vecs[i].sr,
                    vecs[i].w, vecs[i].hold, vecs[i].pulse);
        end
        timing_tick = 1'b0; x_ball = 11'd500;

        // Start pressed during PLAY is ignored.
        do_serve();
        chk("play_entry", game_state, 2);
        start_btn = 1'b1;
        repeat (5) step();
        start_btn = 1'b0;
        repeat (3) step();
        chk("play_ignores_start", game_state, 2);
        chk("play_hold", ball_hold, 0);

        // Left player runs from 1 to 7 and wins.
        for (int k = 2; k <= 7; k++) begin
            if (k > 2) do_serve();
            do_point(11'd1001);
            chk($sformatf("left_pt%0d", k), score_left, k);
            chk($sformatf("left_pulse%0d", k), point_pulse, 1);
        end
        chk_all("win_left", 3, 7, 1, 1, 1, 1);
        do_point(11'd0);
        chk_all("over_no_point", 3, 7, 1, 1, 1, 0);

        // Restart from OVER clears scores and winner.
        press();
        chk_all("restart", 1, 0, 0, 0, 1, 0);

        // Build 3:5 then reset mid-play with the button held.
        for (int k = 0; k < 3; k++) begin do_serve(); do_point(11'd1001); end
        for (int k = 0; k < 5; k++) begin do_serve(); do_point(11'd0); end
        chk_all("score_3_5", 1, 3, 5, 0, 1, 1);
        do_serve();
        chk("play_3_5", game_state, 2);
        rst = 1'b1; start_btn = 1'b1;
        step();
        chk_all("mid_reset", 0, 0, 0, 0, 1, 0);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("held_btn_no_start", game_state, 0);
        start_btn = 1'b0;
        repeat (3) step();
        chk("released_idle", game_state, 0);
        press();
        chk_all("repress_start", 1, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
